// File: rtl/sp_ram_port.sv
// Single-port synchronous RAM with valid/ready request and response channels.
// Define SP_RAM_CLEAR_EN to zero-fill the array after every reset.
module sp_ram_port #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int BYTE_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] req_be,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_data
);

    localparam int NB        = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int RSP_DEPTH = READ_LATENCY + 1;
    localparam int CW        = $clog2(RSP_DEPTH + 1);
    localparam int PW        = $clog2(RSP_DEPTH);
    localparam logic [CW-1:0] FULL_C = CW'(RSP_DEPTH);
    localparam logic [PW-1:0] LAST_P = PW'(RSP_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  run;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  acc;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  pop;
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;

    logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
    logic [PW-1:0]         wp_q;
    logic [PW-1:0]         rp_q;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic [CW-1:0]         out_q;
    logic [CW-1:0]         out_d;

`ifdef SP_RAM_CLEAR_EN
    typedef enum logic {CLEAR, RUN} state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] clr_q;
    logic [ADDR_WIDTH-1:0] clr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        if (state_q == CLEAR) begin
            clr_d = clr_q + ADDR_WIDTH'(1);
            if (clr_q == '1) state_d = RUN;
        end
    end

    assign run      = (state_q == RUN);
    assign clr_we   = (state_q == CLEAR);
    assign clr_addr = clr_q;
`else
    assign run      = 1'b1;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    assign req_ready = run && (out_q < FULL_C);
    assign acc       = req_valid && req_ready;
    assign rd_acc    = acc && !req_write;
    assign wr_acc    = acc && req_write;
    assign rsp_valid = (cnt_q != '0);
    assign rsp_data  = fifo_q[rp_q];
    assign pop       = rsp_valid && rsp_ready;

    // The array itself is never reset.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (req_be[i]) begin
                    mem[req_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                        req_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // The last read stage is the FIFO write itself.
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  s1_v_q;
            logic [DATA_WIDTH-1:0] s1_d_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_v_q <= 1'b0;
                    s1_d_q <= '0;
                end else begin
                    s1_v_q <= rd_acc;
                    if (rd_acc) s1_d_q <= mem[req_addr];
                end
            end

            assign push      = s1_v_q;
            assign push_data = s1_d_q;
        end else begin : g_lat1
            assign push      = rd_acc;
            assign push_data = mem[req_addr];
        end
    endgenerate

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (push && !pop) cnt_d = cnt_q + CW'(1);
        if (!push && pop) cnt_d = cnt_q - CW'(1);
        if (rd_acc && !pop) out_d = out_q + CW'(1);
        if (!rd_acc && pop) out_d = out_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            out_q <= '0;
        end else begin
            if (push) begin
                fifo_q[wp_q] <= push_data;
                wp_q         <= nxt(wp_q);
            end
            if (pop) rp_q <= nxt(rp_q);
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

endmodule

// File: tb/tb_sp_ram_port.sv
// Directed bench for sp_ram_port: 16-bit words, 16 entries, read latency 2.
// Expectations follow SP_RAM_CLEAR_EN when that macro is defined.
module tb_sp_ram_port;

`ifdef SP_RAM_CLEAR_EN
    localparam int          CLR_N    = 16;
    localparam logic        RST_RDY  = 1'b0;
    localparam logic [15:0] RMID_EXP = 16'h0000;
`else
    localparam int          CLR_N    = 0;
    localparam logic        RST_RDY  = 1'b1;
    localparam logic [15:0] RMID_EXP = 16'h0155;
`endif

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [3:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;

    int checks = 0;
    int errors = 0;

    sp_ram_port #(
        .DATA_WIDTH  (16),
        .ADDR_WIDTH  (4),
        .BYTE_WIDTH  (8),
        .READ_LATENCY(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_be   (req_be),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] sval(input int i);
        return 16'h0100 + 16'(i * 17);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag, input int exp_n);
        int n;
        n = 0;
        while (!req_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk(tag, n, exp_n);
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d,
                      input logic [1:0] be);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        chk("wr_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [3:0] a,
                      input logic [15:0] exp);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = a;
        req_be    = 2'b00;
        chk({tag, "_ready"}, req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, "_early"}, rsp_valid, 0);
        @(negedge clk);
        chk({tag, "_valid"}, rsp_valid, 1);
        chk({tag, "_data"}, rsp_data, exp);
        @(negedge clk);
        chk({tag, "_drain"}, rsp_valid, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b0;

        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_req_ready", req_ready, RST_RDY);
        rst_n = 1'b1;
        wait_ready("clear_cycles", CLR_N);

`ifdef SP_RAM_CLEAR_EN
        for (int i = 0; i < 16; i++) rd("clr_zero", 4'(i), 16'h0000);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("clear_restart", 16);
`endif

        // Byte lanes: full write then upper-lane-only write.
        wr(4'hA, 16'h1234, 2'b11);
        wr(4'hA, 16'hFF00, 2'b10);
        rd("be_hi", 4'hA, 16'hFF34);
        wr(4'hB, 16'h0000, 2'b11);
        wr(4'hB, 16'h77A5, 2'b01);
        rd("be_lo", 4'hB, 16'h00A5);

        wr(4'h7, 16'h003C, 2'b11);
        rd("wr_then_rd", 4'h7, 16'h003C);

        // Back-to-back reads: response two cycles after each request cycle.
        for (int i = 0; i < 8; i++) wr(4'(i), sval(i), 2'b11);
        rsp_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            chk("stream_valid", rsp_valid, (k >= 2 && k < 10) ? 1 : 0);
            if (k >= 2 && k < 10) chk("stream_data", rsp_data, sval(k - 2));
            if (k < 8) begin
                req_valid = 1'b1;
                req_write = 1'b0;
                req_addr  = 4'(k);
                chk("stream_ready", req_ready, 1);
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end

        // Back-pressure: three reads fill the response path.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 4'd0;
        chk("bp_rdy0", req_ready, 1);
        @(negedge clk);
        req_addr = 4'd1;
        chk("bp_rdy1", req_ready, 1);
        @(negedge clk);
        req_addr = 4'd2;
        chk("bp_rdy2", req_ready, 1);
        @(negedge clk);
        req_addr = 4'd3;
        chk("bp_full", req_ready, 0);
        chk("bp_head_valid", rsp_valid, 1);
        chk("bp_head_data", rsp_data, sval(0));
        @(negedge clk);
        chk("bp_hold", req_ready, 0);
        chk("bp_keep", rsp_data, sval(0));
        rsp_ready = 1'b1;
        chk("bp_pop_same", req_ready, 0);
        @(negedge clk);
        chk("bp_resume", req_ready, 1);
        chk("bp_d1", rsp_data, sval(1));
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp_d2", rsp_data, sval(2));
        @(negedge clk);
        chk("bp_v3", rsp_valid, 1);
        chk("bp_d3", rsp_data, sval(3));
        @(negedge clk);
        chk("bp_empty", rsp_valid, 0);
        @(negedge clk);
        chk("idle_valid", rsp_valid, 0);
        chk("idle_ready", req_ready, 1);

        // Reset with two responses queued.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 4'd0;
        @(negedge clk);
        req_addr = 4'd1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rmid_queued", rsp_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rmid_async_valid", rsp_valid, 0);
        chk("rmid_async_data", rsp_data, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        wait_ready("rmid_ready", CLR_N);
        chk("rmid_valid_after", rsp_valid, 0);
        rd("rmid_keep", 4'd5, RMID_EXP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
